// File: rtl/etc_event_logger.sv
// Captures one vehicle record per rising edge of done into a small FIFO drained by a host.
// Optional overspeed flagging is built only when ETC_LOG_SPEED_LIMIT_EN is defined.
module etc_event_logger #(
    parameter int unsigned WIDTH_SPEED = 14,
    parameter int unsigned WIDTH_TS    = 16,
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned SYS_FREQ    = 50000000,
    parameter int unsigned SPEED_LIMIT = 60
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              done,
    input  logic [WIDTH_SPEED-1:0]            speed,
    input  logic [1:0]                        valid_Epass,
    input  logic                              rd_en,
    input  logic                              clr_ovf,
    output logic [WIDTH_TS+3+WIDTH_SPEED-1:0] rd_data,
    output logic                              rd_valid,
    output logic                              empty,
    output logic                              full,
    output logic [DEPTH_LOG2:0]               level,
    output logic                              overflow,
    output logic [7:0]                        drop_cnt,
    output logic                              overspeed_irq
);

    localparam int unsigned RecW  = WIDTH_TS + 3 + WIDTH_SPEED;
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned Ticks = (SYS_FREQ / 1000 > 1) ? SYS_FREQ / 1000 : 1;
    localparam int unsigned TickW = (Ticks > 1) ? $clog2(Ticks) : 1;

    logic                  done_q;
    logic [TickW-1:0]      tick_q;
    logic [WIDTH_TS-1:0]   ts_q;
    logic [DEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [RecW-1:0]       mem_q [Depth];
    logic                  capture, tick_tc, do_pop, do_push, drop, overspeed;
    logic [RecW-1:0]       record;

`ifdef ETC_LOG_SPEED_LIMIT_EN
    assign overspeed = (32'(speed) > SPEED_LIMIT);
`else
    logic unused_speed_limit;
    assign overspeed          = 1'b0;
    assign unused_speed_limit = ^SPEED_LIMIT;
`endif

    assign capture = done & ~done_q;
    assign tick_tc = (tick_q == TickW'(Ticks - 1));
    // A pop on an empty FIFO is ignored even if a record is being written this cycle.
    assign do_pop  = rd_en & ~empty;
    assign do_push = capture & (~full | do_pop);
    assign drop    = capture & full & ~do_pop;
    assign record  = {ts_q, valid_Epass, overspeed, speed};

    assign wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= record;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q        <= 1'b1;
            tick_q        <= '0;
            ts_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            empty         <= 1'b1;
            full          <= 1'b0;
            level         <= '0;
            rd_data       <= '0;
            rd_valid      <= 1'b0;
            overflow      <= 1'b0;
            drop_cnt      <= 8'd0;
            overspeed_irq <= 1'b0;
        end else begin
            done_q   <= done;
            tick_q   <= tick_tc ? '0 : tick_q + 1'b1;
            if (tick_tc) begin
                ts_q <= ts_q + 1'b1;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level    <= wr_ptr_d - rd_ptr_d;
            empty    <= (wr_ptr_d == rd_ptr_d);
            full     <= (wr_ptr_d[DEPTH_LOG2-1:0] == rd_ptr_d[DEPTH_LOG2-1:0]) &&
                        (wr_ptr_d[DEPTH_LOG2] != rd_ptr_d[DEPTH_LOG2]);
            rd_valid <= do_pop;
            // When full and popping, both pointers address the same slot; the read sees old data.
            if (do_pop) begin
                rd_data <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            end
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hff) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= 8'd0;
            end
            overspeed_irq <= do_push & overspeed;
        end
    end

endmodule

// File: tb/tb_etc_event_logger.sv
// Directed bench for etc_event_logger: 4 cycles/ms, 4-entry FIFO, 14-bit timestamp so wrap
// is reachable in ~64k cycles.
module tb_etc_event_logger;

    localparam int unsigned WS = 14;
    localparam int unsigned WT = 14;
    localparam int unsigned DL = 2;
    localparam int unsigned RW = WT + 3 + WS;

`ifdef ETC_LOG_SPEED_LIMIT_EN
    localparam logic OV61 = 1'b1;
`else
    localparam logic OV61 = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          done = 1'b1;
    logic [WS-1:0] speed = '0;
    logic [1:0]    valid_epass = 2'b00;
    logic          rd_en = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [RW-1:0] rd_data;
    logic          rd_valid, empty, full, overflow, overspeed_irq;
    logic [DL:0]   level;
    logic [7:0]    drop_cnt;

    etc_event_logger #(
        .WIDTH_SPEED(WS),
        .WIDTH_TS   (WT),
        .DEPTH_LOG2 (DL),
        .SYS_FREQ   (4000),
        .SPEED_LIMIT(60)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .done         (done),
        .speed        (speed),
        .valid_Epass  (valid_epass),
        .rd_en        (rd_en),
        .clr_ovf      (clr_ovf),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .overspeed_irq(overspeed_irq)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; timestamp before edge n is n/4.
    int unsigned cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned target);
        for (int i = 0; i < 100000; i++) begin
            if (cyc == target) break;
            tick();
        end
        check("wait_cyc", 64'(cyc), 64'(target));
    endtask

    function automatic logic [RW-1:0] mk(input int unsigned c, input logic [1:0] ep,
                                         input logic ov, input logic [WS-1:0] sp);
        return {WT'(c / 4), ep, ov, sp};
    endfunction

    // Raise done for one cycle; speeds here stay <= 60 so the overspeed bit is 0.
    task automatic capture(input logic [WS-1:0] sp, input logic [1:0] ep,
                           output logic [RW-1:0] rec);
        speed       = sp;
        valid_epass = ep;
        done        = 1'b1;
        rec         = mk(cyc, ep, 1'b0, sp);
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic pop(input string tag, input logic [RW-1:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check(tag, 64'(rd_data), 64'(exp));
    endtask

    logic [RW-1:0] r [6];
    logic [RW-1:0] ra, rb;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_irq", 64'(overspeed_irq), 64'd0);
        reset_n = 1'b1;

        // done high at release must not capture
        repeat (10) tick();
        check("t1_empty", 64'(empty), 64'd1);
        check("t1_level", 64'(level), 64'd0);

        // First record at timestamp 3
        tick();
        done = 1'b0;
        tick();
        speed       = 14'd45;
        valid_epass = 2'b01;
        done        = 1'b1;
        tick();
        done = 1'b0;
        check("t2_level", 64'(level), 64'd1);
        check("t2_empty", 64'(empty), 64'd0);
        pop("t2_rec", {14'd3, 2'b01, 1'b0, 14'd45});
        check("t2_empty_after", 64'(empty), 64'd1);
        tick();
        check("t2_valid_pulse", 64'(rd_valid), 64'd0);
        check("t2_hold", 64'(rd_data), 64'({14'd3, 2'b01, 1'b0, 14'd45}));

        // Pop while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_empty_valid", 64'(rd_valid), 64'd0);
        check("rd_empty_level", 64'(level), 64'd0);

        // Fill, overflow, drop vs clear
        for (int i = 0; i < 5; i++) begin
            capture(WS'(10 * (i + 1)), 2'(i), r[i]);
            if (i == 3) begin
                check("t3_full", 64'(full), 64'd1);
                check("t3_level4", 64'(level), 64'd4);
                check("t3_no_ovf", 64'(overflow), 64'd0);
            end
        end
        check("t3_ovf", 64'(overflow), 64'd1);
        check("t3_drop1", 64'(drop_cnt), 64'd1);
        check("t3_level_after_drop", 64'(level), 64'd4);
        speed   = 14'd33;
        done    = 1'b1;
        clr_ovf = 1'b1;
        tick();
        done    = 1'b0;
        clr_ovf = 1'b0;
        check("drop_wins_ovf", 64'(overflow), 64'd1);
        check("drop_wins_cnt", 64'(drop_cnt), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) pop($sformatf("t3_rec%0d", i), r[i]);
        check("t3_empty", 64'(empty), 64'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_clr_ovf", 64'(overflow), 64'd0);
        check("t3_clr_cnt", 64'(drop_cnt), 64'd0);

        // Capture and pop together while empty: write only
        speed       = 14'd7;
        valid_epass = 2'b10;
        done        = 1'b1;
        rd_en       = 1'b1;
        ra          = mk(cyc, 2'b10, 1'b0, 14'd7);
        tick();
        done  = 1'b0;
        rd_en = 1'b0;
        check("emp_both_valid", 64'(rd_valid), 64'd0);
        check("emp_both_level", 64'(level), 64'd1);
        tick();
        pop("emp_both_rec", ra);

        // Capture and pop together while full
        for (int i = 0; i < 4; i++) capture(WS'(20 + i), 2'b11, r[i]);
        speed       = 14'd50;
        valid_epass = 2'b00;
        done        = 1'b1;
        rd_en       = 1'b1;
        r[4]        = mk(cyc, 2'b00, 1'b0, 14'd50);
        tick();
        done  = 1'b0;
        rd_en = 1'b0;
        check("t4_valid", 64'(rd_valid), 64'd1);
        check("t4_oldest", 64'(rd_data), 64'(r[0]));
        check("t4_level", 64'(level), 64'd4);
        check("t4_no_drop", 64'(drop_cnt), 64'd0);
        check("t4_no_ovf", 64'(overflow), 64'd0);
        tick();
        for (int i = 1; i < 5; i++) pop($sformatf("t4_rec%0d", i), r[i]);

        // Overspeed threshold
        speed       = 14'd61;
        valid_epass = 2'b11;
        done        = 1'b1;
        ra          = mk(cyc, 2'b11, OV61, 14'd61);
        tick();
        done = 1'b0;
        check("t5_irq61", 64'(overspeed_irq), 64'(OV61));
        tick();
        check("t5_irq61_end", 64'(overspeed_irq), 64'd0);
        speed = 14'd60;
        done  = 1'b1;
        rb    = mk(cyc, 2'b11, 1'b0, 14'd60);
        tick();
        done = 1'b0;
        check("t5_irq60", 64'(overspeed_irq), 64'd0);
        tick();
        pop("t5_rec61", ra);
        check("t5_bit61", 64'(rd_data[WS]), 64'(OV61));
        pop("t5_rec60", rb);
        check("t5_bit60", 64'(rd_data[WS]), 64'd0);

        // Timestamp wrap 16383 -> 0
        wait_cyc(65532);
        speed       = 14'd5;
        valid_epass = 2'b10;
        done        = 1'b1;
        tick();
        done = 1'b0;
        wait_cyc(65536);
        speed = 14'd6;
        done  = 1'b1;
        tick();
        done = 1'b0;
        tick();
        pop("t6_ts_max", {14'd16383, 2'b10, 1'b0, 14'd5});
        pop("t6_ts_wrap", {14'd0, 2'b10, 1'b0, 14'd6});

        // Mid-run reset with level 3 and rd_valid high
        for (int i = 0; i < 4; i++) capture(WS'(i + 1), 2'b01, r[i]);
        pop("t6_pre_rst", r[0]);
        check("t6_level3", 64'(level), 64'd3);
        reset_n = 1'b0;
        #1;
        check("t6_rst_empty", 64'(empty), 64'd1);
        check("t6_rst_level", 64'(level), 64'd0);
        check("t6_rst_valid", 64'(rd_valid), 64'd0);
        check("t6_rst_full", 64'(full), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
